// File: rtl/fpu_pkg.sv
// Shared FPU types: fp32 fields, rounding modes, operand classes, issue FSM states.
// Imported by the adder front end and the adder itself.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [6:0] RM_RNE = 7'b0000001;
  localparam logic [6:0] RM_RTZ = 7'b0000010;
  localparam logic [6:0] RM_RDN = 7'b0000100;
  localparam logic [6:0] RM_RUP = 7'b0001000;
  localparam logic [6:0] RM_RMM = 7'b0010000;

  localparam logic [31:0] QNAN = 32'h7FFFFFFF;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    ISSUE,
    WAIT,
    RESP
  } issue_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational fp32 operand classifier; subnormals count as zero.
// Ports: op (fp32_t operand) -> cls (fp_class_t).
module fp32_classify
  import fpu_pkg::*;
(
  input  fp32_t     op,
  output fp_class_t cls
);

  always_comb begin
    cls = NORMAL;
    unique case (1'b1)
      op.exp == 8'h00:
        cls = ZERO;
      op.exp == 8'hFF && op.frac == '0:
        cls = INF;
      op.exp == 8'hFF && op.frac != '0:
        cls = NAN;
      default:
        cls = NORMAL;
    endcase
  end

endmodule

// File: rtl/fp_add_issue.sv
// Adder front end: unpack, classify, order/align operands, issue to the
// adder, resolve zero and cancellation locally, and return the result.
// Ports: req_* request handshake with raw x/y/sub/rm; rsp_* response
// handshake with z and flags; add_* decomposed-operand adder interface.
module fp_add_issue
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned SHIFT_SAT      = 26
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic        sub_i,
  input  logic [6:0]  rm_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] z_o,
  output logic        invalid_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic        add_ready_o,
  output logic [6:0]  add_rm_o,
  output logic        add_x_sign_o,
  output logic [7:0]  add_x_exp_o,
  output logic [22:0] add_x_frac_o,
  output logic        add_y_sign_o,
  output logic [7:0]  add_y_exp_o,
  output logic [22:0] add_y_frac_o,
  output logic        add_x_greater_o,
  output logic [7:0]  add_exp_shift_o,
  output logic        add_x_inf_o,
  output logic        add_y_inf_o,
  output logic        add_x_nan_o,
  output logic        add_y_nan_o,
  input  logic        add_valid_i,
  input  logic [31:0] add_z_i,
  input  logic        add_invalid_i,
  input  logic        add_overflow_i
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SAT8 = 8'(SHIFT_SAT);

  issue_state_t state_q;
  issue_state_t state_d;

  fp32_t      x_q;
  fp32_t      y_q;
  logic [6:0] rm_q;

  fp_class_t x_cls;
  fp_class_t y_cls;

  logic       greater_q;
  logic [7:0] shift_q;
  logic       x_inf_q;
  logic       y_inf_q;
  logic       x_nan_q;
  logic       y_nan_q;

  logic [CW-1:0] cnt_q;

  logic [31:0] z_q;
  logic        inv_q;
  logic        ovf_q;
  logic        to_q;

  logic        x_zero;
  logic        y_zero;
  logic        special;
  logic        cancel;
  logic        byp;
  logic [31:0] byp_z;
  logic [7:0]  ediff;
  logic [7:0]  shift;
  logic        greater;
  logic        wait_done;

  fp32_classify u_cls_x (
    .op  (x_q),
    .cls (x_cls)
  );

  fp32_classify u_cls_y (
    .op  (y_q),
    .cls (y_cls)
  );

  assign x_zero  = x_cls == ZERO;
  assign y_zero  = y_cls == ZERO;
  assign special = x_cls inside {INF, NAN}
                || y_cls inside {INF, NAN};

  // Equal magnitude, opposite sign; zeros are handled separately.
  assign cancel = !x_zero
               && x_q.exp == y_q.exp
               && x_q.frac == y_q.frac
               && x_q.sign != y_q.sign;

  assign greater = {x_q.exp, x_q.frac} >= {y_q.exp, y_q.frac};

  assign ediff = (x_q.exp >= y_q.exp)
               ? x_q.exp - y_q.exp
               : y_q.exp - x_q.exp;
  assign shift = (ediff > SAT8) ? SAT8 : ediff;

  always_comb begin
    byp   = 1'b0;
    byp_z = '0;
    if (!special) begin
      unique case (1'b1)
        x_zero && y_zero: begin
          byp   = 1'b1;
          byp_z = {x_q.sign & y_q.sign, 31'b0};
        end
        x_zero && !y_zero: begin
          byp   = 1'b1;
          byp_z = y_q;
        end
        !x_zero && y_zero: begin
          byp   = 1'b1;
          byp_z = x_q;
        end
        cancel: begin
          byp   = 1'b1;
          byp_z = '0;
        end
        default: ;
      endcase
    end
  end

  // Valid from the adder wins over the watchdog on the last WAIT cycle.
  assign wait_done = add_valid_i || cnt_q == CNT_LAST;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_valid_i) state_d = CLASSIFY;
      CLASSIFY: state_d = byp ? RESP : ISSUE;
      ISSUE:    state_d = WAIT;
      WAIT:     if (wait_done) state_d = RESP;
      RESP:     if (rsp_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q       <= '0;
      y_q       <= '0;
      rm_q      <= '0;
      greater_q <= 1'b0;
      shift_q   <= '0;
      x_inf_q   <= 1'b0;
      y_inf_q   <= 1'b0;
      x_nan_q   <= 1'b0;
      y_nan_q   <= 1'b0;
      cnt_q     <= '0;
      z_q       <= '0;
      inv_q     <= 1'b0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            x_q  <= fp32_t'(x_i);
            y_q  <= fp32_t'(y_i ^ {sub_i, 31'b0});
            rm_q <= rm_i;
          end
        end
        CLASSIFY: begin
          greater_q <= greater;
          shift_q   <= shift;
          x_inf_q   <= x_cls == INF;
          y_inf_q   <= y_cls == INF;
          x_nan_q   <= x_cls == NAN;
          y_nan_q   <= y_cls == NAN;
          if (byp) begin
            z_q   <= byp_z;
            inv_q <= 1'b0;
            ovf_q <= 1'b0;
            to_q  <= 1'b0;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
        end
        WAIT: begin
          if (add_valid_i) begin
            z_q   <= add_z_i;
            inv_q <= add_invalid_i;
            ovf_q <= add_overflow_i;
            to_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            z_q   <= QNAN;
            inv_q <= 1'b0;
            ovf_q <= 1'b0;
            to_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = state_q == IDLE;
  assign add_ready_o = state_q == ISSUE;
  assign rsp_valid_o = state_q == RESP;

  assign z_o        = z_q;
  assign invalid_o  = inv_q;
  assign overflow_o = ovf_q;
  assign timeout_o  = to_q;

  assign add_rm_o        = rm_q;
  assign add_x_sign_o    = x_q.sign;
  assign add_x_exp_o     = x_q.exp;
  assign add_x_frac_o    = x_q.frac;
  assign add_y_sign_o    = y_q.sign;
  assign add_y_exp_o     = y_q.exp;
  assign add_y_frac_o    = y_q.frac;
  assign add_x_greater_o = greater_q;
  assign add_exp_shift_o = shift_q;
  assign add_x_inf_o     = x_inf_q;
  assign add_y_inf_o     = y_inf_q;
  assign add_x_nan_o     = x_nan_q;
  assign add_y_nan_o     = y_nan_q;

endmodule

// File: tb/tb_fp_add_issue.sv
// Self-checking bench for fp_add_issue with a stub adder.
// Transaction-level model predicts issue fields, response and latency.
module tb_fp_add_issue;

  localparam int TO  = 16;
  localparam int SAT = 26;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic        sub_i;
  logic [6:0]  rm_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] z_o;
  logic        invalid_o;
  logic        overflow_o;
  logic        timeout_o;
  logic        add_ready_o;
  logic [6:0]  add_rm_o;
  logic        add_x_sign_o;
  logic [7:0]  add_x_exp_o;
  logic [22:0] add_x_frac_o;
  logic        add_y_sign_o;
  logic [7:0]  add_y_exp_o;
  logic [22:0] add_y_frac_o;
  logic        add_x_greater_o;
  logic [7:0]  add_exp_shift_o;
  logic        add_x_inf_o;
  logic        add_y_inf_o;
  logic        add_x_nan_o;
  logic        add_y_nan_o;
  logic        add_valid_i;
  logic [31:0] add_z_i;
  logic        add_invalid_i;
  logic        add_overflow_i;

  fp_add_issue #(
    .TIMEOUT_CYCLES (TO),
    .SHIFT_SAT      (SAT)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .x_i             (x_i),
    .y_i             (y_i),
    .sub_i           (sub_i),
    .rm_i            (rm_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .z_o             (z_o),
    .invalid_o       (invalid_o),
    .overflow_o      (overflow_o),
    .timeout_o       (timeout_o),
    .add_ready_o     (add_ready_o),
    .add_rm_o        (add_rm_o),
    .add_x_sign_o    (add_x_sign_o),
    .add_x_exp_o     (add_x_exp_o),
    .add_x_frac_o    (add_x_frac_o),
    .add_y_sign_o    (add_y_sign_o),
    .add_y_exp_o     (add_y_exp_o),
    .add_y_frac_o    (add_y_frac_o),
    .add_x_greater_o (add_x_greater_o),
    .add_exp_shift_o (add_exp_shift_o),
    .add_x_inf_o     (add_x_inf_o),
    .add_y_inf_o     (add_y_inf_o),
    .add_x_nan_o     (add_x_nan_o),
    .add_y_nan_o     (add_y_nan_o),
    .add_valid_i     (add_valid_i),
    .add_z_i         (add_z_i),
    .add_invalid_i   (add_invalid_i),
    .add_overflow_i  (add_overflow_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [6:0]  rm;
    bit          byp;
    logic [31:0] z;
    logic        inv;
    logic        ovf;
    logic        to;
    int          lat;
    logic        greater;
    logic [7:0]  shift;
    logic        xinf;
    logic        yinf;
    logic        xnan;
    logic        ynan;
  } exp_t;

  // Local resolution rule: no inf/nan, then zero or exact cancellation.
  function automatic void model_bypass(input logic [31:0] x,
                                       input logic [31:0] y,
                                       output bit byp,
                                       output logic [31:0] z);
    bit xz, yz, sp;
    xz = x[30:23] == 8'd0;
    yz = y[30:23] == 8'd0;
    sp = x[30:23] == 8'hFF || y[30:23] == 8'hFF;
    byp = 0;
    z = 32'h0;
    if (!sp) begin
      if (xz && yz) begin
        byp = 1;
        z = {x[31] & y[31], 31'b0};
      end else if (xz) begin
        byp = 1;
        z = y;
      end else if (yz) begin
        byp = 1;
        z = x;
      end else if (x[30:0] == y[30:0] && x[31] != y[31]) begin
        byp = 1;
        z = 32'h0;
      end
    end
  endfunction

  function automatic int model_shift(input logic [31:0] x,
                                     input logic [31:0] y);
    int d;
    d = int'(x[30:23]) - int'(y[30:23]);
    if (d < 0) d = -d;
    if (d > SAT) d = SAT;
    return d;
  endfunction

  function automatic exp_t predict(input logic [31:0] x,
                                   input logic [31:0] yr,
                                   input logic sub,
                                   input logic [6:0] rm,
                                   input int alat,
                                   input logic [31:0] az,
                                   input logic ai,
                                   input logic ao);
    exp_t r;
    bit b;
    logic [31:0] bz;
    r.x = x;
    r.y = sub ? (yr ^ 32'h80000000) : yr;
    r.rm = rm;
    model_bypass(r.x, r.y, b, bz);
    r.byp = b;
    r.greater = r.x[30:0] >= r.y[30:0];
    r.shift = 8'(model_shift(r.x, r.y));
    r.xinf = r.x[30:0] == 31'h7F800000;
    r.yinf = r.y[30:0] == 31'h7F800000;
    r.xnan = r.x[30:23] == 8'hFF && r.x[22:0] != 23'd0;
    r.ynan = r.y[30:23] == 8'hFF && r.y[22:0] != 23'd0;
    if (b) begin
      r.z = bz; r.inv = 0; r.ovf = 0; r.to = 0; r.lat = 2;
    end else if (alat >= 1 && alat <= TO) begin
      r.z = az; r.inv = ai; r.ovf = ao; r.to = 0; r.lat = 3 + alat;
    end else begin
      r.z = 32'h7FFFFFFF; r.inv = 0; r.ovf = 0; r.to = 1;
      r.lat = 3 + TO;
    end
    return r;
  endfunction

  // Stub adder programming for the next request.
  int          st_lat;
  logic [31:0] st_z;
  logic        st_inv;
  logic        st_ovf;

  initial begin
    int l;
    add_valid_i = 0;
    add_z_i = 0;
    add_invalid_i = 0;
    add_overflow_i = 0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && add_ready_o && st_lat > 0) begin
        l = st_lat;
        repeat (l) @(posedge clk_i);
        #1;
        add_valid_i = 1;
        add_z_i = st_z;
        add_invalid_i = st_inv;
        add_overflow_i = st_ovf;
        @(posedge clk_i);
        #1;
        add_valid_i = 0;
        add_z_i = 0;
        add_invalid_i = 0;
        add_overflow_i = 0;
      end
    end
  end

  exp_t        e;
  bit          have = 0;
  bit          issued = 0;
  bit          rsp_seen = 0;
  bit          b2b = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          pulses = 0;
  int          meas_lat = 0;
  int          last_rsp_cyc = 0;
  int          done_cnt = 0;
  logic [31:0] last_z = 0;
  logic        last_inv = 0;
  logic        last_to = 0;
  logic        last_greater = 0;
  logic [7:0]  last_shift = 0;
  logic        last_xinf = 0;
  logic        last_yinf = 0;
  int          last_lat = 0;
  int          last_pulses = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        have = 0;
        issued = 0;
        rsp_seen = 0;
        pulses = 0;
      end else begin
        chk("req_ready", 32'(req_ready_o), 32'(!have));
        if (add_ready_o) begin
          pulses++;
          chk("pulse_expected", 32'(have && !e.byp), 1);
          chk("pulse_lat", 32'(cyc - hs_cyc), 2);
          issued = 1;
          last_greater = add_x_greater_o;
          last_shift = add_exp_shift_o;
          last_xinf = add_x_inf_o;
          last_yinf = add_y_inf_o;
        end
        if (issued && have && !rsp_valid_o) begin
          chk("x_fields", {add_x_sign_o, add_x_exp_o, add_x_frac_o}, e.x);
          chk("y_fields", {add_y_sign_o, add_y_exp_o, add_y_frac_o}, e.y);
          chk("rm", 32'(add_rm_o), 32'(e.rm));
          chk("greater", 32'(add_x_greater_o), 32'(e.greater));
          chk("shift", 32'(add_exp_shift_o), 32'(e.shift));
          chk("class",
              32'({add_x_inf_o, add_y_inf_o, add_x_nan_o, add_y_nan_o}),
              32'({e.xinf, e.yinf, e.xnan, e.ynan}));
        end
        if (rsp_valid_o) begin
          chk("rsp_expected", 32'(have), 1);
          if (have) begin
            if (!rsp_seen) begin
              rsp_seen = 1;
              meas_lat = cyc - hs_cyc;
              chk("latency", 32'(meas_lat), 32'(e.lat));
            end
            chk("z", z_o, e.z);
            chk("flags", 32'({invalid_o, overflow_o, timeout_o}),
                32'({e.inv, e.ovf, e.to}));
            if (rsp_ready_i) begin
              chk("pulse_count", 32'(pulses), e.byp ? 0 : 1);
              last_z = z_o;
              last_inv = invalid_o;
              last_to = timeout_o;
              last_lat = meas_lat;
              last_pulses = pulses;
              have = 0;
              issued = 0;
              last_rsp_cyc = cyc;
              done_cnt++;
            end
          end
        end
        if (req_valid_i && req_ready_o) begin
          if (b2b) begin
            chk("b2b_accept", 32'(cyc - last_rsp_cyc), 1);
            b2b = 0;
          end
          e = predict(x_i, y_i, sub_i, rm_i, st_lat, st_z, st_inv, st_ovf);
          have = 1;
          hs_cyc = cyc;
          pulses = 0;
          rsp_seen = 0;
        end
      end
    end
  end

  task automatic drive_req(input logic [31:0] x, input logic [31:0] y,
                           input logic sub, input logic [6:0] rm,
                           input int lat, input logic [31:0] az,
                           input logic ai, input logic ao);
    st_lat = lat;
    st_z = az;
    st_inv = ai;
    st_ovf = ao;
    x_i = x;
    y_i = y;
    sub_i = sub;
    rm_i = rm;
    req_valid_i = 1;
  endtask

  task automatic wait_hs();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!req_ready_o && n < 50);
    chk("req_accept", 32'(req_ready_o), 1);
    @(posedge clk_i);
    #1;
    req_valid_i = 0;
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (done_cnt < tgt && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("rsp_done", 32'(done_cnt >= tgt), 1);
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     input logic sub, input logic [6:0] rm,
                     input int lat, input logic [31:0] az,
                     input logic ai, input logic ao);
    int tgt;
    tgt = done_cnt + 1;
    @(posedge clk_i);
    #1;
    drive_req(x, y, sub, rm, lat, az, ai, ao);
    wait_hs();
    wait_done(tgt);
  endtask

  localparam logic [6:0] RNE = 7'b0000001;
  localparam logic [6:0] RTZ = 7'b0000010;

  initial begin
    bit          pb;
    logic [31:0] pz;
    int          tgt;

    rst_ni = 0;
    req_valid_i = 0;
    x_i = 0;
    y_i = 0;
    sub_i = 0;
    rm_i = 0;
    rsp_ready_i = 1;
    st_lat = 0;
    st_z = 0;
    st_inv = 0;
    st_ovf = 0;

    model_bypass(32'h00000000, 32'h40490FDB, pb, pz);
    chk("model_zero_x", pz, 32'h40490FDB);
    model_bypass(32'h3F800000, 32'hBF800000, pb, pz);
    chk("model_cancel", 32'({pb, pz[31]}), 32'({1'b1, 1'b0}));
    model_bypass(32'h7F800000, 32'hFF800000, pb, pz);
    chk("model_inf_issue", 32'(pb), 0);
    chk("model_shift_sat", 32'(model_shift(32'h7E800000, 32'h3F800000)), 26);

    @(negedge clk_i);
    chk("rst_req_ready", 32'(req_ready_o), 1);
    chk("rst_outs", 32'({rsp_valid_o, add_ready_o, invalid_o, overflow_o,
                         timeout_o, add_x_greater_o}), 0);
    chk("rst_z", z_o, 0);
    chk("rst_shift", 32'(add_exp_shift_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1;

    run(32'h3F800000, 32'h40000000, 0, RNE, 2, 32'h40400000, 0, 0);
    chk("t1_z", last_z, 32'h40400000);
    chk("t1_greater", 32'(last_greater), 0);
    chk("t1_shift", 32'(last_shift), 1);
    chk("t1_pulses", 32'(last_pulses), 1);

    run(32'h7F800000, 32'hFF800000, 0, RNE, 1, 32'h7FFFFFFF, 1, 0);
    chk("t2_inf", 32'({last_xinf, last_yinf}), 32'h3);
    chk("t2_z", last_z, 32'h7FFFFFFF);
    chk("t2_inv", 32'(last_inv), 1);

    run(32'h00000000, 32'h40490FDB, 0, RNE, 1, 32'hDEADBEEF, 0, 0);
    chk("t3_z", last_z, 32'h40490FDB);
    chk("t3_lat", 32'(last_lat), 2);
    chk("t3_pulses", 32'(last_pulses), 0);

    run(32'h3F800000, 32'h3F800000, 1, RNE, 1, 32'hDEADBEEF, 0, 0);
    chk("t4_z", last_z, 32'h00000000);
    chk("t4_pulses", 32'(last_pulses), 0);

    run(32'h80000000, 32'h80000000, 0, RNE, 1, 32'hDEADBEEF, 0, 0);
    chk("t5_z", last_z, 32'h80000000);

    run(32'h00000001, 32'hC0400000, 0, RNE, 1, 32'hDEADBEEF, 0, 0);
    chk("t6_z", last_z, 32'hC0400000);

    run(32'h7E800000, 32'h3F800000, 0, RTZ, 4, 32'h7E800000, 0, 0);
    chk("t7_shift", 32'(last_shift), 26);
    chk("t7_greater", 32'(last_greater), 1);

    run(32'h3F800000, 32'h3F800000, 0, RNE, 1, 32'h40000000, 0, 0);
    chk("t8_tie", 32'({last_greater, last_shift}), 32'h100);

    run(32'h7FC00000, 32'h00000000, 0, RNE, 2, 32'h7FC00000, 0, 0);
    chk("t9_pulses", 32'(last_pulses), 1);

    run(32'h7F7FFFFF, 32'h7F7FFFFF, 0, RTZ, 3, 32'h7F7FFFFF, 0, 1);

    run(32'h40000000, 32'h3F800000, 1, RNE, TO, 32'h3F800000, 0, 0);
    chk("t11_to", 32'(last_to), 0);
    chk("t11_lat", 32'(last_lat), 3 + TO);

    run(32'h40000000, 32'h3F800000, 0, RNE, TO + 1, 32'h40400000, 0, 0);
    chk("t12_z", last_z, 32'h7FFFFFFF);
    chk("t12_to", 32'(last_to), 1);
    repeat (4) @(negedge clk_i);

    tgt = done_cnt + 2;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 0;
    drive_req(32'h3F800000, 32'h40000000, 0, RNE, 2, 32'h40400000, 0, 0);
    wait_hs();
    for (int n = 0; n < 50 && !rsp_valid_o; n++) @(negedge clk_i);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      chk("stall_hold", 32'({rsp_valid_o, req_ready_o}), 32'h2);
      chk("stall_z", z_o, 32'h40400000);
    end
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1;
    b2b = 1;
    drive_req(32'h40400000, 32'hC0400000, 0, RNE, 1, 32'hDEADBEEF, 0, 0);
    wait_hs();
    wait_done(tgt);
    chk("b2b_z", last_z, 32'h00000000);
    chk("b2b_flag", 32'(b2b), 0);

    run(32'h3F800000, 32'h40000000, 0, RNE, -1, 32'h0, 0, 0);
    chk("t14_to", 32'({last_z[31:28], last_to}), 32'hF);
    chk("t14_lat", 32'(last_lat), 3 + TO);

    @(posedge clk_i);
    #1;
    drive_req(32'h3F800000, 32'h40000000, 0, RNE, -1, 32'h0, 0, 0);
    wait_hs();
    repeat (5) @(negedge clk_i);
    #2;
    rst_ni = 0;
    #1;
    chk("arst_req_ready", 32'(req_ready_o), 1);
    chk("arst_outs", 32'({rsp_valid_o, add_ready_o, timeout_o,
                          add_x_greater_o}), 0);
    chk("arst_fields", 32'({add_x_exp_o, add_exp_shift_o}), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1;

    run(32'h3F800000, 32'h40000000, 0, RNE, 2, 32'h40400000, 0, 0);
    chk("post_rst_z", last_z, 32'h40400000);

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
